snapshot_access_seq: RTL and testbench

SNAPSHOT_ACCESS_SEQ -- requirements
Module: snapshot_access_seq

---
 rtl/snapshot_access_seq.sv | 179 +++++++++++++++++
 tb/tb_snapshot_access_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_access_seq.sv
// snapshot_access_seq
// Splits one wide register access into a sequence of bus-word strobes to a
// partitioned snapshot register. Reads run partition 0 first, so partition 0
// triggers the snapshot capture. Writes run partition 0 last, so partition 0
// commits the register.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   soft_rst          synchronous abort, active-high
//   req_vld/req_rdy   wide request handshake; req_wr selects write (1) or read (0)
//   req_wdata         wide write data
//   rsp_vld/rsp_rdy   response handshake; rsp_rdata is the read result, zero for writes
//   snap_rd_en        one-hot per-partition read strobe
//   snap_wr_en        one-hot per-partition write strobe
//   snap_wr_data      write word in the slice of the active partition, other slices zero
//   snap_rd_data      read data; slice i valid while partition i is strobed
//
// state | meaning
// IDLE  | ready for a request
// RD    | strobing partition idx for read, ascending
// WR    | strobing partition idx for write, descending
// RSP   | response held until rsp_rdy
module snapshot_access_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_WIDTH     = 36,
  parameter int PARTITION_CNT = (REG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                soft_rst,
  input  logic                                req_vld,
  output logic                                req_rdy,
  input  logic                                req_wr,
  input  logic [REG_WIDTH-1:0]                req_wdata,
  output logic                                rsp_vld,
  input  logic                                rsp_rdy,
  output logic [REG_WIDTH-1:0]                rsp_rdata,
  output logic [PARTITION_CNT-1:0]            snap_rd_en,
  output logic [PARTITION_CNT-1:0]            snap_wr_en,
  output logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_wr_data,
  input  logic [DATA_WIDTH*PARTITION_CNT-1:0] snap_rd_data
);

  localparam int PW = DATA_WIDTH * PARTITION_CNT;
  localparam int IW = (PARTITION_CNT > 1) ? $clog2(PARTITION_CNT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(PARTITION_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                wr_q;
  logic [REG_WIDTH-1:0] wdata_q;
  logic [PW-1:0]       rdata_q;
  logic [PW-1:0]       wdata_pad;
  logic                accept;

  assign accept = (state == S_IDLE) && req_vld && !soft_rst;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // request latch and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (soft_rst) begin
      rdata_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_wr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == S_RD) begin
        rdata_q[idx*DATA_WIDTH +: DATA_WIDTH] <= snap_rd_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // next-state
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (soft_rst) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_vld) begin
            if (req_wr) begin
              state_nxt = S_WR;
              idx_nxt   = IDX_LAST;
            end else begin
              state_nxt = S_RD;
              idx_nxt   = '0;
            end
          end
        end
        S_RD: begin
          if (idx == IDX_LAST) begin
            state_nxt = S_RSP;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
        S_WR: begin
          if (idx == '0) begin
            state_nxt = S_RSP;
          end else begin
            idx_nxt = idx - 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_rdy) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // bits above REG_WIDTH in the last partition are written as zero
  always_comb begin
    wdata_pad                = '0;
    wdata_pad[REG_WIDTH-1:0] = wdata_q;
  end

  // outputs; soft_rst masks the strobe already decoded for the current cycle
  always_comb begin
    req_rdy      = (state == S_IDLE) && !soft_rst;
    rsp_vld      = (state == S_RSP) && !soft_rst;
    snap_rd_en   = '0;
    snap_wr_en   = '0;
    snap_wr_data = '0;
    for (int i = 0; i < PARTITION_CNT; i++) begin
      if ((idx == IW'(i)) && !soft_rst) begin
        if (state == S_RD) begin
          snap_rd_en[i] = 1'b1;
        end
        if (state == S_WR) begin
          snap_wr_en[i] = 1'b1;
          snap_wr_data[i*DATA_WIDTH +: DATA_WIDTH] = wdata_pad[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // read result truncated to the register width; writes report zero
  assign rsp_rdata = wr_q ? '0 : rdata_q[REG_WIDTH-1:0];

  // padding bits of the last read partition are captured but never reported
  if (PW > REG_WIDTH) begin : g_pad
    logic unused_rd_pad;
    assign unused_rd_pad = ^rdata_q[PW-1:REG_WIDTH];
  end

endmodule

// File: tb/tb_snapshot_access_seq.sv
// Testbench for snapshot_access_seq: directed vectors with a response
// scoreboard. Instance a uses 32/36 (two partitions), instance b uses 32/32.
module tb_snapshot_access_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_rst = 1'b0;

  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_wr = 1'b0;
  logic [35:0] req_wdata = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b1;
  logic [35:0] rsp_rdata;
  logic [1:0]  snap_rd_en;
  logic [1:0]  snap_wr_en;
  logic [63:0] snap_wr_data;
  logic [63:0] snap_rd_data = '0;

  logic        b_req_vld = 1'b0;
  logic        b_req_rdy;
  logic        b_req_wr = 1'b0;
  logic [31:0] b_req_wdata = '0;
  logic        b_rsp_vld;
  logic [31:0] b_rsp_rdata;
  logic [0:0]  b_rd_en;
  logic [0:0]  b_wr_en;
  logic [31:0] b_wr_data;
  logic [31:0] b_rd_data = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_exp;

  always #5 clk = ~clk;

  snapshot_access_seq #(.DATA_WIDTH(32), .REG_WIDTH(36)) dut_a (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .snap_rd_en(snap_rd_en), .snap_wr_en(snap_wr_en),
    .snap_wr_data(snap_wr_data), .snap_rd_data(snap_rd_data)
  );

  snapshot_access_seq #(.DATA_WIDTH(32), .REG_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .soft_rst(1'b0),
    .req_vld(b_req_vld), .req_rdy(b_req_rdy), .req_wr(b_req_wr), .req_wdata(b_req_wdata),
    .rsp_vld(b_rsp_vld), .rsp_rdy(1'b1), .rsp_rdata(b_rsp_rdata),
    .snap_rd_en(b_rd_en), .snap_wr_en(b_wr_en),
    .snap_wr_data(b_wr_data), .snap_rd_data(b_rd_data)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // presents a request for one edge; returns in the first cycle after acceptance
  task automatic issue(input logic wr, input logic [35:0] wd);
    chk("req_rdy_before_issue", req_rdy, 1);
    req_vld   = 1'b1;
    req_wr    = wr;
    req_wdata = wd;
    tick();
    req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && !req_rdy; k++) tick();
    chk("idle_timeout", req_rdy, 1);
  endtask

  // scoreboard monitor and strobe exclusivity
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_vld && rsp_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata %h expected no response", rsp_rdata);
        end else begin
          mon_exp = exp_q.pop_front();
          n_checks--;
          chk("rsp_rdata", rsp_rdata, mon_exp);
        end
      end
      n_checks++;
      if ((snap_rd_en != 0 && snap_wr_en != 0) || !$onehot0(snap_rd_en) || !$onehot0(snap_wr_en)) begin
        n_fail++;
        $display("FAIL strobe_excl: got rd_en %b wr_en %b expected at most one bit", snap_rd_en, snap_wr_en);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rd_en", snap_rd_en, 0);
    chk("rst_wr_en", snap_wr_en, 0);
    chk("rst_wr_data", snap_wr_data, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_rdy", req_rdy, 1);

    // read; upper pad bits of slice 1 must be truncated away
    snap_rd_data = {32'hFFFF_FFFA, 32'h1234_5678};
    exp_q.push_back(36'hA_1234_5678);
    issue(1'b0, 36'h0);
    chk("rd_t1_rd_en", snap_rd_en, 2'b01);
    chk("rd_t1_wr_en", snap_wr_en, 2'b00);
    chk("rd_t1_req_rdy", req_rdy, 0);
    tick();
    chk("rd_t2_rd_en", snap_rd_en, 2'b10);
    tick();
    chk("rd_t3_rsp_vld", rsp_vld, 1);
    chk("rd_t3_rd_en", snap_rd_en, 2'b00);
    tick();
    chk("rd_idle", req_rdy, 1);

    // write
    exp_q.push_back(36'h0);
    issue(1'b1, 36'h5_DEAD_BEEF);
    chk("wr_t1_wr_en", snap_wr_en, 2'b10);
    chk("wr_t1_wr_data", snap_wr_data, {32'h0000_0005, 32'h0});
    chk("wr_t1_rd_en", snap_rd_en, 2'b00);
    tick();
    chk("wr_t2_wr_en", snap_wr_en, 2'b01);
    chk("wr_t2_wr_data", snap_wr_data, {32'h0, 32'hDEAD_BEEF});
    tick();
    chk("wr_t3_rsp_vld", rsp_vld, 1);
    chk("wr_t3_rsp_rdata", rsp_rdata, 0);
    chk("wr_t3_wr_en", snap_wr_en, 2'b00);
    tick();
    chk("wr_idle", req_rdy, 1);

    // backpressure
    rsp_rdy = 1'b0;
    snap_rd_data = {32'h0000_0003, 32'hCAFE_F00D};
    exp_q.push_back(36'h3_CAFE_F00D);
    issue(1'b0, 36'h0);
    tick();
    tick();
    chk("bp_rsp_vld", rsp_vld, 1);
    snap_rd_data = {32'h5555_5555, 32'hAAAA_AAAA};
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_vld", rsp_vld, 1);
      chk("bp_hold_rdata", rsp_rdata, 36'h3_CAFE_F00D);
      chk("bp_req_rdy", req_rdy, 0);
      chk("bp_rd_en", snap_rd_en, 0);
      chk("bp_wr_en", snap_wr_en, 0);
    end
    rsp_rdy = 1'b1;
    tick();
    chk("bp_idle", req_rdy, 1);
    chk("bp_rsp_done", rsp_vld, 0);

    // soft reset in the cycle after the first write strobe
    issue(1'b1, 36'hF_0000_0001);
    chk("sr_t1_wr_en", snap_wr_en, 2'b10);
    tick();
    soft_rst = 1'b1;
    #1;
    chk("sr_no_commit", snap_wr_en, 2'b00);
    chk("sr_no_rsp", rsp_vld, 0);
    tick();
    soft_rst = 1'b0;
    #1;
    chk("sr_req_rdy", req_rdy, 1);
    chk("sr_wr_en_after", snap_wr_en, 2'b00);
    chk("sr_rsp_vld_after", rsp_vld, 0);
    chk("sr_rdata_clr", rsp_rdata, 0);
    tick();
    chk("sr_rsp_vld_later", rsp_vld, 0);

    // async reset mid-read
    snap_rd_data = {32'h0000_0001, 32'h1111_1111};
    issue(1'b0, 36'h0);
    chk("ar_t1_rd_en", snap_rd_en, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("ar_rd_en", snap_rd_en, 0);
    chk("ar_wr_en", snap_wr_en, 0);
    chk("ar_wr_data", snap_wr_data, 0);
    chk("ar_rsp_vld", rsp_vld, 0);
    chk("ar_rsp_rdata", rsp_rdata, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_req_rdy", req_rdy, 1);
    chk("ar_rd_en_after", snap_rd_en, 0);
    snap_rd_data = {32'h0000_0007, 32'h89AB_CDEF};
    exp_q.push_back(36'h7_89AB_CDEF);
    issue(1'b0, 36'h0);
    chk("ar2_t1_rd_en", snap_rd_en, 2'b01);
    tick();
    chk("ar2_t2_rd_en", snap_rd_en, 2'b10);
    tick();
    chk("ar2_t3_rsp_vld", rsp_vld, 1);
    tick();
    wait_idle();

    // single-partition instance
    b_rd_data = 32'h1357_9BDF;
    chk("b_req_rdy", b_req_rdy, 1);
    b_req_vld = 1'b1;
    b_req_wr  = 1'b0;
    tick();
    b_req_vld = 1'b0;
    chk("b_rd_t1_rd_en", b_rd_en, 1'b1);
    chk("b_rd_t1_rsp_vld", b_rsp_vld, 0);
    tick();
    chk("b_rd_t2_rsp_vld", b_rsp_vld, 1);
    chk("b_rd_t2_rdata", b_rsp_rdata, 32'h1357_9BDF);
    chk("b_rd_t2_rd_en", b_rd_en, 1'b0);
    tick();
    chk("b_rd_idle", b_req_rdy, 1);
    b_req_vld   = 1'b1;
    b_req_wr    = 1'b1;
    b_req_wdata = 32'h2468_ACE0;
    tick();
    b_req_vld = 1'b0;
    chk("b_wr_t1_wr_en", b_wr_en, 1'b1);
    chk("b_wr_t1_wr_data", b_wr_data, 32'h2468_ACE0);
    tick();
    chk("b_wr_t2_rsp_vld", b_rsp_vld, 1);
    chk("b_wr_t2_rdata", b_rsp_rdata, 0);
    tick();
    chk("b_wr_idle", b_req_rdy, 1);

    tick();
    chk("pending_rsp", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
